// File: rtl/prim_fifo_pkg.sv
// Shared width helpers and watermark configuration bundle for the prim_fifo family.
package prim_fifo_pkg;

    localparam int unsigned WmW = 8;

    typedef struct packed {
        logic [WmW-1:0] hwm;
        logic [WmW-1:0] lwm;
    } fifo_wm_cfg_t;

    // Occupancy counter width: must represent 0..Depth inclusive.
    function automatic int depth_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/prim_fifo_sync_wm_if.sv
// Valid/ready write and read channels of the watermark FIFO.
interface prim_fifo_sync_wm_if #(
    parameter int Width = 16
) ();
    logic             wvalid;
    logic             wready;
    logic [Width-1:0] wdata;
    logic             rvalid;
    logic             rready;
    logic [Width-1:0] rdata;

    modport master (output wvalid, wdata, rready, input wready, rvalid, rdata);
    modport slave  (input wvalid, wdata, rready, output wready, rvalid, rdata);
endinterface

// File: rtl/prim_fifo_ptr.sv
// Index-plus-wrap-bit pointer; the index wraps at Depth-1 so any depth works.
module prim_fifo_ptr
    import prim_fifo_pkg::*;
#(
    parameter  int Depth = 4,
    localparam int PtrW  = ptr_w(Depth)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            inc_i,
    output logic [PtrW-1:0] idx_o,
    output logic            wrap_o
);

    logic [PtrW-1:0] idx_r;
    logic            wrap_r;
    logic            last_s;

    assign last_s = (idx_r == PtrW'(Depth - 1));

    // Pointer state: clear has priority over increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_r  <= {PtrW{1'b0}};
            wrap_r <= 1'b0;
        end else if (clr_i) begin
            idx_r  <= {PtrW{1'b0}};
            wrap_r <= 1'b0;
        end else if (inc_i) begin
            if (last_s) begin
                idx_r  <= {PtrW{1'b0}};
                wrap_r <= ~wrap_r;
            end else begin
                idx_r  <= idx_r + PtrW'(1'b1);
                wrap_r <= wrap_r;
            end
        end else begin
            idx_r  <= idx_r;
            wrap_r <= wrap_r;
        end
    end

    assign idx_o  = idx_r;
    assign wrap_o = wrap_r;

endmodule

// File: rtl/prim_fifo_sync_wm.sv
// Single-clock FIFO with pass-through, programmable watermarks, crossing event
// and an optional drop-when-full mode with a saturating drop counter.
module prim_fifo_sync_wm
    import prim_fifo_pkg::*;
#(
    parameter  int Width             = 16,
    parameter  int Depth             = 4,
    parameter  bit Pass              = 1'b1,
    parameter  bit OutputZeroIfEmpty = 1'b1,
    parameter  bit DropWhenFull      = 1'b0,
    parameter  int DropCntW          = 8,
    localparam int DepthW            = depth_w(Depth)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    prim_fifo_sync_wm_if.slave    fifo,
    output logic [DepthW-1:0]     depth,
    input  logic [DepthW-1:0]     hwm_i,
    input  logic [DepthW-1:0]     lwm_i,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic                  hwm_evt_o,
    output logic [DropCntW-1:0]   drop_cnt_o
);

    localparam int PtrW = ptr_w(Depth);

    if (Depth < 1) begin : g_bad_depth
        $fatal(1, "prim_fifo_sync_wm: Depth must be at least 1");
    end

    logic [Width-1:0]    storage_r [Depth];
    logic [PtrW-1:0]     widx_s, ridx_s;
    logic                wwrap_s, rwrap_s;
    logic                full_s, empty_s, pass_s, rvalid_s;
    logic                wr_en_s, rd_en_s, drop_s, af_s;
    logic [DepthW-1:0]   depth_s;
    logic [Width-1:0]    head_s;
    logic                af_prev_r, hwm_evt_r;
    logic [DropCntW-1:0] drop_cnt_r;

    // Fullness and occupancy derived from the wrap-bit pointers.
    always_comb begin
        full_s  = (widx_s == ridx_s) && (wwrap_s != rwrap_s);
        empty_s = (widx_s == ridx_s) && (wwrap_s == rwrap_s);
        if (full_s) begin
            depth_s = DepthW'(Depth);
        end else if (wwrap_s == rwrap_s) begin
            depth_s = DepthW'(widx_s) - DepthW'(ridx_s);
        end else begin
            depth_s = DepthW'(Depth) - DepthW'(ridx_s) + DepthW'(widx_s);
        end
    end

    // Handshake: an empty FIFO with Pass forwards the incoming word directly.
    always_comb begin
        pass_s   = Pass && empty_s && fifo.wvalid;
        rvalid_s = ~empty_s | pass_s;
        head_s   = pass_s ? fifo.wdata : storage_r[ridx_s];
        if (OutputZeroIfEmpty && !rvalid_s) begin
            fifo.rdata = {Width{1'b0}};
        end else begin
            fifo.rdata = head_s;
        end
        fifo.rvalid = rvalid_s;
        fifo.wready = DropWhenFull ? 1'b1 : ~full_s;
        wr_en_s     = fifo.wvalid & fifo.wready & ~full_s & ~clr_i;
        rd_en_s     = rvalid_s & fifo.rready;
        drop_s      = DropWhenFull & fifo.wvalid & full_s;
    end

    prim_fifo_ptr #(.Depth(Depth)) u_wptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (clr_i),
        .inc_i  (wr_en_s),
        .idx_o  (widx_s),
        .wrap_o (wwrap_s)
    );

    prim_fifo_ptr #(.Depth(Depth)) u_rptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (clr_i),
        .inc_i  (rd_en_s),
        .idx_o  (ridx_s),
        .wrap_o (rwrap_s)
    );

    // Storage array; deliberately not reset or cleared.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            storage_r[widx_s] <= fifo.wdata;
        end
    end

    assign af_s = (hwm_i != {DepthW{1'b0}}) && (depth_s >= hwm_i);

    // Watermark edge detector and saturating drop counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            af_prev_r  <= 1'b0;
            hwm_evt_r  <= 1'b0;
            drop_cnt_r <= {DropCntW{1'b0}};
        end else if (clr_i) begin
            af_prev_r  <= 1'b0;
            hwm_evt_r  <= 1'b0;
            drop_cnt_r <= {DropCntW{1'b0}};
        end else begin
            af_prev_r <= af_s;
            hwm_evt_r <= af_s & ~af_prev_r;
            if (drop_s && (drop_cnt_r != {DropCntW{1'b1}})) begin
                drop_cnt_r <= drop_cnt_r + DropCntW'(1'b1);
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    assign depth          = depth_s;
    assign almost_full_o  = af_s;
    assign almost_empty_o = (depth_s <= lwm_i);
    assign hwm_evt_o      = hwm_evt_r;
    assign drop_cnt_o     = drop_cnt_r;

endmodule

// File: tb/tb_prim_fifo_sync_wm.sv
// Directed and randomized bench for prim_fifo_sync_wm against a queue-based reference model.
module tb_prim_fifo_sync_wm;

    logic       clk, rst_n;
    logic [1:0] sel;
    logic       wv, rr, clr;
    logic [7:0] wd;
    logic [2:0] hwm_v, lwm_v;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state for the currently selected instance.
    logic [7:0] q[$];
    int         m_cnt;
    bit         m_prev, m_evt;
    int         cfg_depth, cfg_cntmax;
    bit         cfg_pass, cfg_drop;

    prim_fifo_sync_wm_if #(.Width(8)) if_a ();
    prim_fifo_sync_wm_if #(.Width(8)) if_b ();
    prim_fifo_sync_wm_if #(.Width(8)) if_c ();

    logic [1:0] dep_a;
    logic [2:0] dep_b, dep_c;
    logic       af_a, af_b, af_c, ae_a, ae_b, ae_c, ev_a, ev_b, ev_c;
    logic [7:0] dc_a, dc_c;
    logic [1:0] dc_b;
    logic [1:0] hwm_a, lwm_a;

    assign hwm_a = hwm_v[1:0];
    assign lwm_a = lwm_v[1:0];

    assign if_a.wvalid = wv & (sel == 2'd0);
    assign if_a.wdata  = wd;
    assign if_a.rready = rr & (sel == 2'd0);
    assign if_b.wvalid = wv & (sel == 2'd1);
    assign if_b.wdata  = wd;
    assign if_b.rready = rr & (sel == 2'd1);
    assign if_c.wvalid = wv & (sel == 2'd2);
    assign if_c.wdata  = wd;
    assign if_c.rready = rr & (sel == 2'd2);

    prim_fifo_sync_wm #(.Width(8), .Depth(3), .Pass(1'b0), .OutputZeroIfEmpty(1'b1),
                        .DropWhenFull(1'b0), .DropCntW(8)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr & (sel == 2'd0)), .fifo(if_a),
        .depth(dep_a), .hwm_i(hwm_a), .lwm_i(lwm_a), .almost_full_o(af_a),
        .almost_empty_o(ae_a), .hwm_evt_o(ev_a), .drop_cnt_o(dc_a));

    prim_fifo_sync_wm #(.Width(8), .Depth(4), .Pass(1'b1), .OutputZeroIfEmpty(1'b1),
                        .DropWhenFull(1'b1), .DropCntW(2)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr & (sel == 2'd1)), .fifo(if_b),
        .depth(dep_b), .hwm_i(hwm_v), .lwm_i(lwm_v), .almost_full_o(af_b),
        .almost_empty_o(ae_b), .hwm_evt_o(ev_b), .drop_cnt_o(dc_b));

    prim_fifo_sync_wm #(.Width(8), .Depth(4), .Pass(1'b1), .OutputZeroIfEmpty(1'b1),
                        .DropWhenFull(1'b0), .DropCntW(8)) u_dut_c (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr & (sel == 2'd2)), .fifo(if_c),
        .depth(dep_c), .hwm_i(hwm_v), .lwm_i(lwm_v), .almost_full_o(af_c),
        .almost_empty_o(ae_c), .hwm_evt_o(ev_c), .drop_cnt_o(dc_c));

    logic       o_wready, o_rvalid, o_af, o_ae, o_evt;
    logic [7:0] o_rdata, o_drop;
    logic [2:0] o_depth;

    // Route the selected instance's outputs to one observation bundle.
    always_comb begin
        o_wready = if_a.wready; o_rvalid = if_a.rvalid; o_rdata = if_a.rdata;
        o_depth  = {1'b0, dep_a}; o_af = af_a; o_ae = ae_a; o_evt = ev_a; o_drop = dc_a;
        case (sel)
            2'd1: begin
                o_wready = if_b.wready; o_rvalid = if_b.rvalid; o_rdata = if_b.rdata;
                o_depth  = dep_b; o_af = af_b; o_ae = ae_b; o_evt = ev_b; o_drop = {6'd0, dc_b};
            end
            2'd2: begin
                o_wready = if_c.wready; o_rvalid = if_c.rvalid; o_rdata = if_c.rdata;
                o_depth  = dep_c; o_af = af_c; o_ae = ae_c; o_evt = ev_c; o_drop = dc_c;
            end
            default: begin
                o_wready = if_a.wready; o_rvalid = if_a.rvalid; o_rdata = if_a.rdata;
                o_depth  = {1'b0, dep_a}; o_af = af_a; o_ae = ae_a; o_evt = ev_a; o_drop = dc_a;
            end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h (sel=%0d t=%0t)", tag, obs, exp, sel, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_cnt  = 0;
        m_prev = 1'b0;
        m_evt  = 1'b0;
    endtask

    // Compare every output against what the rules predict from the queue contents.
    task automatic check_outputs();
        int         sz;
        bit         full, e_rv;
        logic [7:0] e_rd;
        sz   = q.size();
        full = (sz == cfg_depth);
        e_rv = (sz > 0) || (cfg_pass && wv);
        e_rd = !e_rv ? 8'h00 : ((sz > 0) ? q[0] : wd);
        chk("wready", 32'(o_wready), 32'(cfg_drop ? 1'b1 : !full));
        chk("rvalid", 32'(o_rvalid), 32'(e_rv));
        chk("rdata", 32'(o_rdata), 32'(e_rd));
        chk("depth", 32'(o_depth), 32'(sz));
        chk("almost_full", 32'(o_af), 32'((hwm_v != 3'd0) && (sz >= int'(hwm_v))));
        chk("almost_empty", 32'(o_ae), 32'(sz <= int'(lwm_v)));
        chk("hwm_evt", 32'(o_evt), 32'(m_evt));
        chk("drop_cnt", 32'(o_drop), 32'(m_cnt));
    endtask

    task automatic model_edge();
        int sz;
        bit full, af, e_rv, acc, rd;
        if (clr) begin
            model_reset();
        end else begin
            sz   = q.size();
            full = (sz == cfg_depth);
            af   = (hwm_v != 3'd0) && (sz >= int'(hwm_v));
            e_rv = (sz > 0) || (cfg_pass && wv);
            m_evt  = af && !m_prev;
            m_prev = af;
            acc = wv && !full;
            rd  = e_rv && rr;
            if (cfg_drop && wv && full && (m_cnt < cfg_cntmax)) m_cnt++;
            if (!(rd && sz == 0)) begin
                if (rd) void'(q.pop_front());
                if (acc) q.push_back(wd);
            end
        end
    endtask

    task automatic cyc(input bit v, input logic [7:0] d, input bit r, input bit c);
        wv = v; wd = d; rr = r; clr = c;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_cfg(input logic [1:0] s, input int dep, input bit pass, input bit drop, input int cmax);
        sel = s; cfg_depth = dep; cfg_pass = pass; cfg_drop = drop; cfg_cntmax = cmax;
        wv = 1'b0; rr = 1'b0; clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_reset();
    endtask

    task automatic rand_phase(input int n);
        bit v, r, c;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(15) == 0) begin
                hwm_v = 3'($urandom_range(4));
                lwm_v = 3'($urandom_range(4));
            end
            if ((i / 50) % 2 == 0) begin
                v = ($urandom_range(9) < 7);
                r = ($urandom_range(9) < 3);
            end else begin
                v = ($urandom_range(9) < 3);
                r = ($urandom_range(9) < 7);
            end
            c = ($urandom_range(39) == 0);
            cyc(v, 8'($urandom), r, c);
        end
    endtask

    initial begin
        rst_n = 1'b1; sel = 2'd0; wv = 1'b0; rr = 1'b0; clr = 1'b0; wd = 8'h00;
        hwm_v = 3'd2; lwm_v = 3'd1;
        cfg_depth = 3; cfg_pass = 1'b0; cfg_drop = 1'b0; cfg_cntmax = 255;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        check_outputs();
        chk("reset_wready", 32'(o_wready), 32'd1);
        chk("reset_ae", 32'(o_ae), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Depth 3, no pass: fill, watermark crossing, ordered drain.
        cyc(1'b1, 8'hA1, 1'b0, 1'b0);
        chk("fill_depth1", 32'(o_depth), 32'd1);
        cyc(1'b1, 8'hA2, 1'b0, 1'b0);
        chk("fill_depth2", 32'(o_depth), 32'd2);
        chk("af_rise", 32'(o_af), 32'd1);
        chk("evt_not_yet", 32'(o_evt), 32'd0);
        cyc(1'b1, 8'hA3, 1'b0, 1'b0);
        chk("fill_depth3", 32'(o_depth), 32'd3);
        chk("full_wready", 32'(o_wready), 32'd0);
        chk("evt_pulse", 32'(o_evt), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("evt_single", 32'(o_evt), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("head_order", 32'(o_rdata), 32'(8'hA1 + 8'(i)));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drained_depth", 32'(o_depth), 32'd0);
        chk("drained_rdata", 32'(o_rdata), 32'd0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
            chk("wrap_depth", 32'(o_depth <= 3'd1), 32'd1);
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Depth 4 with pass, normal full behaviour.
        hwm_v = 3'd3; lwm_v = 3'd1;
        set_cfg(2'd2, 4, 1'b1, 1'b0, 255);
        cyc(1'b1, 8'h5C, 1'b1, 1'b0);
        wv = 1'b0; rr = 1'b0; #1;
        chk("pass_depth", 32'(o_depth), 32'd0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
        chk("full_depth", 32'(o_depth), 32'd4);
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        chk("full_rw_depth", 32'(o_depth), 32'd3);
        cyc(1'b1, 8'h77, 1'b0, 1'b0);
        chk("late_write_depth", 32'(o_depth), 32'd4);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 8'h21, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        chk("pre_clr_depth", 32'(o_depth), 32'd2);
        cyc(1'b1, 8'h99, 1'b1, 1'b1);
        wv = 1'b0; rr = 1'b0; #1;
        chk("clr_depth", 32'(o_depth), 32'd0);
        chk("clr_rvalid", 32'(o_rvalid), 32'd0);
        chk("clr_drop", 32'(o_drop), 32'd0);
        rand_phase(400);

        // Asynchronous reset in the middle of a burst.
        cyc(1'b1, 8'h31, 1'b0, 1'b0);
        cyc(1'b1, 8'h32, 1'b0, 1'b0);
        wv = 1'b1; wd = 8'h3C; rr = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("rst_depth", 32'(o_depth), 32'd0);
        chk("rst_pass_rvalid", 32'(o_rvalid), 32'd1);
        wv = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        model_edge();
        #1;

        // Drop-when-full with a 2-bit saturating counter.
        hwm_v = 3'd4; lwm_v = 3'd0;
        set_cfg(2'd1, 4, 1'b1, 1'b1, 3);
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
            chk("drop_wready", 32'(o_wready), 32'd1);
        end
        chk("drop_depth", 32'(o_depth), 32'd4);
        chk("drop_sat", 32'(o_drop), 32'd3);
        for (int i = 0; i < 4; i++) begin
            chk("drop_keep", 32'(o_rdata), 32'(8'hB0 + 8'(i)));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        rand_phase(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prim_fifo_sync_wm.md
Name: prim_fifo_sync_wm

Overview:
- Synchronous single-clock FIFO with watermarks. It is the parametrised successor of the basic sync FIFO primitive.
- Keeps the existing valid/ready ports, the optional pass-through, and the occupancy output.
- Adds the following:
  - programmable high and low watermarks with level flags;
  - a one-cycle high-watermark crossing event;
  - optional zeroing of read data when empty;
  - a drop-when-full mode with a saturating drop counter.
- Used as the buffering stage in front of peripheral DMA/interrupt logic, where software-visible thresholds are needed.

Parameters:
- Width, 16: data width in bits, ≥1.
- Depth, 4: number of entries, ≥1. Elaboration assertion on Depth==0.
- Pass, 1'b1: when empty, an incoming write is visible on the read side in the same cycle.
- OutputZeroIfEmpty, 1'b1: rdata is forced to 0 whenever rvalid=0.
- DropWhenFull, 1'b0: wready is tied to 1; writes arriving while full are discarded and counted.
- DropCntW, 8: width of the drop counter.
- DepthW (derived, not overridable): $clog2(Depth+1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- clr_i  in  1  synchronous clear: empties the FIFO and zeroes drop_cnt_o.
- wvalid  in  1  write request.
- wready  out  1  write accept.
- wdata  in  Width  write data.
- rvalid  out  1  read data valid.
- rready  in  1  read accept.
- rdata  out  Width  read data.
- depth  out  DepthW  current occupancy, 0..Depth.
- hwm_i  in  DepthW  high watermark; 0 disables the high watermark.
- lwm_i  in  DepthW  low watermark.
- almost_full_o  out  1  depth ≥ hwm_i (and hwm_i≠0).
- almost_empty_o  out  1  depth ≤ lwm_i.
- hwm_evt_o  out  1  registered single-cycle pulse on a 0→1 transition of almost_full_o.
- drop_cnt_o  out  DropCntW  saturating count of dropped writes (DropWhenFull only, else 0).

Behaviour:
- Reset values:
  - Pointers 0, depth=0, drop_cnt_o=0, hwm_evt_o=0.
  - wready=1.
  - rvalid = Pass & wvalid.
  - almost_empty_o=1.
  - almost_full_o = (hwm_i≠0) & (hwm_i==0 …); in practice 0 for any legal hwm_i>0.
- Pointers:
  - Each pointer is a $clog2(Depth)-bit index (minimum 1 bit) plus a wrap bit.
  - When the index equals Depth-1, an increment sets the index to 0 and toggles the wrap bit. This keeps non-power-of-two depths correct.
- Full and empty:
  - full = (indices equal) & (wrap bits differ).
  - fifo_empty = pointers equal.
- Occupancy:
  - depth = Depth when full.
  - Otherwise, with equal wrap bits: depth = widx - ridx.
  - Otherwise: depth = Depth - ridx + widx.
  - All arithmetic is done in DepthW bits.
- Write side:
  - wready = ~full, or 1 when DropWhenFull.
  - A write is accepted when wvalid & wready & ~full. It stores wdata at the write index on the clock edge.
  - In DropWhenFull mode, wvalid & full is a drop: no storage update, and drop_cnt_o increments, saturating at all-ones.
- Read side:
  - Without Pass: rvalid = ~fifo_empty and rdata = storage[ridx], i.e. zero-latency read of the head entry.
  - With Pass, while fifo_empty & wvalid: rvalid=1 and rdata=wdata combinationally.
  - With Pass, if rready is also high in that cycle, both pointers advance. Net occupancy is unchanged and the entry counts as consumed.
  - A read is accepted when rvalid & rready.
- Simultaneous read and write when not empty and not full: both pointers advance and depth is unchanged.
- Simultaneous read and write when full:
  - In normal mode wready=0, so only the read completes.
  - In DropWhenFull mode the write is still dropped. Fullness is evaluated before the read in the same cycle.
- OutputZeroIfEmpty: rdata='0 whenever rvalid=0.
- Watermarks:
  - almost_full_o and almost_empty_o are combinational from depth and are re-evaluated immediately when hwm_i/lwm_i change.
  - hwm_evt_o: a flop holds the previous almost_full_o; hwm_evt_o = almost_full_o & ~prev, registered so the pulse appears one cycle after the crossing.
- clr_i:
  - Takes priority over the same-cycle read/write. The next cycle shows depth=0, drop_cnt_o=0, and prev almost_full=0.
  - Storage contents are not cleared.
- Reset asserted mid-transfer: all state returns to reset values asynchronously. Storage is not reset.

Decomposition:
- Package prim_fifo_pkg holds:
  - the DepthW/pointer-width helper functions, so every FIFO variant computes widths identically;
  - a struct bundling {hwm, lwm} for register-file hookup.
- One sub-module, prim_fifo_ptr: wrap-bit pointer counter with clr and increment, parametrised by Depth. It is instantiated twice, once for the write pointer and once for the read pointer.
- Storage, flags and the drop counter stay in the top level.

Test Plan:
- Depth=3, Width=8, Pass=0, hwm=2, lwm=1. Write 0xA1, 0xA2, 0xA3 back-to-back:
  - depth goes 1, 2, 3;
  - wready=0 after the third write;
  - almost_full_o rises on depth=2, with hwm_evt_o high for exactly one cycle one clock later;
  - reads return A1, A2, A3 in order, after which depth=0 and rdata=0.
- Wrap-around, Depth=3: 10 interleaved single writes and reads. Every read returns the matching write, and depth never exceeds 1 through pointer wraps at index 2.
- Pass=1 with the FIFO empty, wvalid=1, wdata=0x5C, rready=1 in the same cycle: rvalid=1, rdata=0x5C, and depth stays 0 next cycle.
- DropWhenFull=1, Depth=4, DropCntW=2:
  - fill 4 entries, then issue 5 more writes;
  - wready stays 1, depth=4, drop_cnt_o saturates at 3;
  - stored data equals the first 4 words.
- Full with simultaneous read and write (DropWhenFull=0): only the read completes, depth goes 4→3, and the write is accepted on the following cycle.
- With depth=2, assert clr_i together with wvalid/rready:
  - next cycle depth=0, rvalid=0, drop_cnt_o=0;
  - asserting rst_ni low mid-burst gives the same result asynchronously.
